vram_writer: RTL

CPU-side write port for the single-port 16 KB video RAM that the ULA reads through `va`/`vramdata`. It detects Z80 memory writes to 0x4000–0x7FFF and queues them in a small FIFO. It retires each queued write into video RAM only in clk7 cycles where the ULA is not fetching, and stalls the CPU through `wait_n` when the queue is full. It sits between the CPU bus and the video RAM, beside the ULA, and owns the RAM address/data/write-enable mux.

---
 rtl/vram_writer.sv | 99 +++++++++
 1 files changed

// File: rtl/vram_writer.sv
// CPU-side write queue for the 16 KB video RAM: captures Z80 writes to 0x4000-0x7FFF
// and retires them into RAM in cycles the ULA leaves free, stalling the CPU when full.
module vram_writer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk7,
  input  logic                          rst_n,
  input  logic [15:0]                   a,
  input  logic [7:0]                    din,
  input  logic                          mreq_n,
  input  logic                          wr_n,
  input  logic                          ula_fetch,
  output logic [13:0]                   vram_a,
  output logic [7:0]                    vram_dout,
  output logic                          vram_we,
  output logic                          wait_n,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef struct packed {
    logic [13:0] addr;
    logic [7:0]  data;
  } wr_req_t;

  typedef enum logic [1:0] {IDLE, PEND, DONE} state_t;

  state_t                     state, state_nxt;
  wr_req_t [FIFO_DEPTH-1:0]   mem;
  logic [PW-1:0]              wr_ptr, rd_ptr;
  logic                       armed;
  logic                       hit, strobe_off, full, pop, can_push, push;

  assign strobe_off = mreq_n | wr_n;
  assign hit        = !strobe_off && (a[15:14] == 2'b01);
  assign full       = (level == LW'(FIFO_DEPTH));
  assign pop        = (level != '0) && !ula_fetch;
  // A pop in the same cycle frees the slot the push needs.
  assign can_push   = !full || pop;
  assign wait_n     = (state != PEND);

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    case (state)
      IDLE: if (hit && armed) begin
        if (can_push) begin
          push      = 1'b1;
          state_nxt = DONE;
        end else begin
          state_nxt = PEND;
        end
      end
      PEND: if (strobe_off) begin
        state_nxt = IDLE;
      end else if (can_push) begin
        push      = 1'b1;
        state_nxt = DONE;
      end
      DONE: if (strobe_off) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk7) begin
    if (!rst_n) begin
      state     <= IDLE;
      armed     <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      vram_we   <= 1'b0;
      vram_a    <= '0;
      vram_dout <= '0;
    end else begin
      state   <= state_nxt;
      // A strobe already low when reset releases must end before a write is accepted.
      if (strobe_off) armed <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        {vram_a, vram_dout} <= mem[rd_ptr];
        rd_ptr              <= rd_ptr + PW'(1);
      end
      vram_we <= pop;
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk7) begin
    if (push) mem[wr_ptr] <= '{addr: a[13:0], data: din};
  end

endmodule
